// File: rtl/mem_stream_reader.sv
// Streams a contiguous, wrapping address range out of a single-port synchronous RAM
// onto a valid/ready interface, through a 2-entry output buffer with credit-based issue.
module mem_stream_reader #(
    parameter int unsigned WORD_SIZE = 32,
    parameter int unsigned NUM_WORDS = 16,
    parameter int unsigned ADDR_BITS = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [ADDR_BITS-1:0] base_addr,
    input  logic [ADDR_BITS:0]   count,
    output logic                 busy,
    output logic                 done,
    output logic                 mem_we,
    output logic [ADDR_BITS-1:0] mem_addr,
    input  logic [WORD_SIZE-1:0] mem_data_out,
    output logic [WORD_SIZE-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready
);
    localparam int unsigned CNT_W = ADDR_BITS + 1;

    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

    state_t               state;
    logic [1:0]           occ;
    logic                 inflight;
    logic [WORD_SIZE-1:0] tail_data;
    logic [CNT_W-1:0]     issue_left;
    logic [CNT_W-1:0]     out_left;
    logic                 pop_c;
    logic                 issue_c;
    logic [ADDR_BITS-1:0] next_addr_c;

    assign mem_we      = 1'b0;
    assign pop_c       = out_valid && out_ready;
    // A slot is free once buffered + in-flight words, net of this cycle's pop, drop below 2.
    assign issue_c     = (state == READ) && ((3'(occ) + 3'(inflight)) < (3'd2 + 3'(pop_c)));
    assign next_addr_c = ADDR_BITS'((32'(mem_addr) + 32'd1) % NUM_WORDS);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            mem_addr   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            tail_data  <= '0;
            occ        <= 2'd0;
            inflight   <= 1'b0;
            issue_left <= '0;
            out_left   <= '0;
        end else begin
            done     <= 1'b0;
            inflight <= issue_c;

            // Output buffer: out_data is the head entry, tail_data the second entry.
            if (inflight && !pop_c) begin
                if (occ == 2'd0) begin
                    out_data <= mem_data_out;
                end else begin
                    tail_data <= mem_data_out;
                end
                occ       <= occ + 2'd1;
                out_valid <= 1'b1;
            end else if (!inflight && pop_c) begin
                out_data  <= tail_data;
                occ       <= occ - 2'd1;
                out_valid <= (occ == 2'd2);
            end else if (inflight && pop_c) begin
                if (occ == 2'd2) begin
                    out_data  <= tail_data;
                    tail_data <= mem_data_out;
                end else begin
                    out_data <= mem_data_out;
                end
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        if (count != '0) begin
                            mem_addr   <= base_addr;
                            issue_left <= count;
                            out_left   <= count;
                            busy       <= 1'b1;
                            state      <= READ;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                READ: begin
                    if (issue_c) begin
                        mem_addr   <= next_addr_c;
                        issue_left <= issue_left - CNT_W'(1);
                        if (issue_left == CNT_W'(1)) begin
                            state <= DRAIN;
                        end
                    end
                end
                default: begin
                end
            endcase

            if ((state != IDLE) && pop_c) begin
                out_left <= out_left - CNT_W'(1);
                if (out_left == CNT_W'(1)) begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            end
        end
    end
endmodule

// File: doc/mem_stream_reader.md
Name: mem_stream_reader

Overview:
- Read-side initiator for the single-port synchronous RAM block: WORD_SIZE-bit words, NUM_WORDS deep, one-cycle registered read, write enable and one shared address.
- On a start command, the block walks a contiguous address range, issues one read per cycle and absorbs the one-cycle RAM latency.
- Words are delivered in order on a valid/ready stream to downstream consumers such as sprite/pixel logic.
- A 2-entry output buffer lets the block sustain one word per cycle and tolerate arbitrary back-pressure.

Parameters:
- WORD_SIZE, 32, width of a RAM word and of out_data.
- NUM_WORDS, 16, RAM depth; must equal 2**ADDR_BITS.
- ADDR_BITS, 4, RAM address width.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  command strobe; sampled only in IDLE.
- base_addr  in  ADDR_BITS  first address to read; sampled with start.
- count  in  ADDR_BITS+1  number of words to read, 0..NUM_WORDS; sampled with start.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse after the last word handshakes on the output.
- mem_we  out  1  RAM write enable; tied 0.
- mem_addr  out  ADDR_BITS  RAM address, driven from a register.
- mem_data_out  in  WORD_SIZE  RAM read data; valid the cycle after the address is presented.
- out_data  out  WORD_SIZE  stream data (buffer head).
- out_valid  out  1  stream valid.
- out_ready  in  1  downstream ready; a transfer occurs when out_valid && out_ready at a rising edge.

Behaviour:
- Reset (async, reset_n=0):
  - State = IDLE; mem_addr=0, busy=0, done=0, out_valid=0, out_data=0.
  - Buffer emptied, in-flight flag cleared, remaining and issued counters=0.
  - Reset mid-transfer abandons the transfer; no done pulse.
- FSM states: IDLE, READ, DRAIN.
- IDLE:
  - start=1 and count!=0: load addr=base_addr, issue_left=count, out_left=count; go to READ; busy=1 from the next cycle.
  - start=1 and count=0: no reads; done=1 for exactly one cycle on the next cycle; stay IDLE.
- READ:
  - mem_addr holds the current address.
  - A read is "issued" in a cycle when credit = 2 - (buffer occupancy) - (in-flight) > 0 after counting a same-cycle output pop.
  - On issue: set in-flight for the next cycle, addr <= addr+1, issue_left--.
  - Address wraps modulo NUM_WORDS (base 14, count 4 reads 14,15,0,1).
  - When issue_left reaches 0, go to DRAIN.
- In-flight capture: the cycle after an issue, mem_data_out is written into the buffer tail.
- DRAIN: no new issues; wait until out_left=0.
- Output stream:
  - Each handshake decrements out_left.
  - When the final handshake occurs: done=1 next cycle, busy=0 next cycle, return to IDLE.
- Stream rules:
  - out_data/out_valid come from the buffer head, registered.
  - out_valid never drops without a handshake, and out_data is stable while out_valid=1 and out_ready=0.
  - Simultaneous push and pop is legal at any occupancy.
  - The buffer never overflows; credit accounting guarantees this.
- Latency: with start accepted at edge E, the first read address appears after E, and out_valid first rises after E+2.
- Throughput: with out_ready=1 continuously, one word per cycle; done follows the last word's handshake by 1 cycle.
- start while busy is ignored; base_addr and count are don't-care outside IDLE+start.
- mem_we is 0 at all times, including during reset.

Test Plan:
- Reset: assert reset_n=0 mid-READ → all outputs 0 immediately; release, start base=0 count=4 → normal transfer, no stale words.
- Basic: RAM[i]=0x1000+i, out_ready=1, start base=3 count=5 → out_valid rises 2 cycles after the start edge; words 0x1003..0x1007 on consecutive cycles; done pulse 1 cycle after the 5th handshake; busy high across the transfer.
- Wrap: base=14 count=4 → mem_addr sequence 14,15,0,1; outputs RAM[14],RAM[15],RAM[0],RAM[1].
- Back-pressure: count=16, out_ready random 30% high → all 16 words in order, none lost or duplicated, out_data stable while stalled, never more than 2 reads outstanding+buffered.
- count=0 → done high exactly 1 cycle, busy stays 0, out_valid stays 0, no mem_addr change.
- start pulsed while busy (base=9 count=2) → ignored; original transfer completes unchanged; a single done pulse.
